// File: rtl/demux8b_pkg.sv
// Shared definitions for the mux8b link: word/select widths, receiver states and
// the bit-reversed select-to-slot mapping used by both ends of the link.
package demux8b_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } rx_state_t;

    function automatic logic [SEL_W-1:0] sel_to_idx(input logic [SEL_W-1:0] s);
        return {s[0], s[1], s[2]};
    endfunction

    // Returns 1 when word plus its even-parity bit holds an odd number of ones.
    function automatic logic even_parity_err(input logic [WORD_W-1:0] word,
                                             input logic              par);
        return ^{word, par};
    endfunction

endpackage

// File: rtl/demux8b_slot.sv
// Shadow register for demux8b_rx: writes one bit into the slot selected by the
// bit-reversed select code; word_o is the register content with that write merged in.
module demux8b_slot
    import demux8b_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              bit_i,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;
    logic [WORD_W-1:0] merged_s;
    logic [WORD_W-1:0] base_s;
    logic [SEL_W-1:0]  idx_s;

    // Decode the select and build both the merged and the cleared-then-written word.
    always_comb begin
        idx_s    = sel_to_idx(sel_i);
        merged_s = word_q;
        base_s   = {WORD_W{1'b0}};
        if (we_i) begin
            merged_s[idx_s] = bit_i;
            base_s[idx_s]   = bit_i;
        end else begin
            merged_s = word_q;
            base_s   = {WORD_W{1'b0}};
        end
        if (clr_i) begin
            word_d = base_s;
        end else begin
            word_d = merged_s;
        end
    end

    // Shadow register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= {WORD_W{1'b0}};
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = merged_s;

endmodule

// File: rtl/demux8b_rx.sv
// Serial-to-parallel receiver for the mux8b link (bit counter, frame FSM, output
// registers). Define DEMUX8B_RX_PARITY_EN to add a trailing even-parity bit per frame.
module demux8b_rx
    import demux8b_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             din,
    input  logic             din_valid,
    output logic [SEL_W-1:0] s,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             parity_err
);

    rx_state_t         state_q, state_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              perr_q, perr_d;

    logic              sh_clr_s;
    logic              sh_we_s;
    logic [SEL_W-1:0]  sh_sel_s;
    logic [WORD_W-1:0] sh_word_s;

    demux8b_slot u_shadow (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sh_clr_s),
        .we_i   (sh_we_s),
        .sel_i  (sh_sel_s),
        .bit_i  (din),
        .word_o (sh_word_s)
    );

    // Next-state: counter, frame FSM, shadow write control and output loads.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
`ifdef DEMUX8B_RX_PARITY_EN
        perr_d   = perr_q;
`else
        perr_d   = 1'b0;
`endif
        sh_clr_s = 1'b0;
        sh_we_s  = 1'b0;
        sh_sel_s = s_q;

        if (sync) begin
            // A sync edge drops the partial word; a valid bit on it becomes bit 0.
            state_d  = COLLECT;
            sh_clr_s = 1'b1;
            if (din_valid) begin
                sh_we_s  = 1'b1;
                sh_sel_s = 3'd0;
                s_d      = 3'd1;
            end else begin
                s_d      = 3'd0;
            end
        end else if (din_valid) begin
            case (state_q)
                COLLECT: begin
                    sh_we_s = 1'b1;
                    s_d     = s_q + 3'd1;
                    if (s_q == 3'd7) begin
`ifdef DEMUX8B_RX_PARITY_EN
                        state_d = PARITY;
`else
                        dout_d  = sh_word_s;
                        dv_d    = 1'b1;
`endif
                    end else begin
                        state_d = COLLECT;
                    end
                end
                PARITY: begin
`ifdef DEMUX8B_RX_PARITY_EN
                    dout_d  = sh_word_s;
                    dv_d    = 1'b1;
                    perr_d  = even_parity_err(sh_word_s, din);
                    s_d     = 3'd0;
`endif
                    state_d = COLLECT;
                end
                default: begin
                    state_d = COLLECT;
                    s_d     = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            s_q     <= 3'd0;
            dout_q  <= {WIDTH{1'b0}};
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            perr_q  <= perr_d;
        end
    end

    assign s          = s_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign parity_err = perr_q;

endmodule
